// File: rtl/relu_pipe.sv
// Two-stage valid/ready activation stage: per-lane bypass / ReLU / leaky / clamp,
// frame-end forwarding and a per-beat count of zero lanes.
module relu_pipe #(
  parameter int DW      = 16,
  parameter int CH      = 6,
  parameter int LEAK_SH = 3,
  parameter int CLAMP   = 6 << (DW / 2),
  parameter int ZW      = $clog2(CH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW*CH-1:0] in_data,
  input  logic [1:0]       in_mode,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW*CH-1:0] out_data,
  output logic             out_last,
  output logic [ZW-1:0]    out_zero_cnt
);

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'd0,
    MODE_RELU   = 2'd1,
    MODE_LEAKY  = 2'd2,
    MODE_CLAMP  = 2'd3
  } mode_e;

  localparam logic signed [DW-1:0] CLAMP_C = DW'(CLAMP);

  // Every result fits in DW bits, so no saturation beyond the clamp mode is needed.
  function automatic logic [DW-1:0] act_lane(input logic [DW-1:0] x_u, input mode_e mode);
    logic signed [DW-1:0] x;
    x        = signed'(x_u);
    act_lane = x_u;
    case (mode)
      MODE_RELU:  act_lane = x[DW-1] ? '0 : x_u;
      MODE_LEAKY: act_lane = x[DW-1] ? DW'(x >>> LEAK_SH) : x_u;
      MODE_CLAMP: begin
        if (x[DW-1])          act_lane = '0;
        else if (x > CLAMP_C) act_lane = CLAMP_C;
        else                  act_lane = x_u;
      end
      default:    act_lane = x_u;
    endcase
  endfunction

  logic             s1_valid_q, s2_valid_q;
  logic [DW*CH-1:0] s1_data_q, s2_data_q, s1_data_d;
  logic             s1_last_q, s2_last_q;
  logic [ZW-1:0]    s2_zcnt_q, zcnt_d;
  logic             s1_en, s2_en;

  // NOTE: always_comb outputs get a default before the loop so no latch is inferred.
  always_comb begin
    s1_data_d = '0;
    for (int i = 0; i < CH; i++) begin
      s1_data_d[i*DW +: DW] = act_lane(in_data[i*DW +: DW], mode_e'(in_mode));
    end
  end

  always_comb begin
    zcnt_d = '0;
    for (int i = 0; i < CH; i++) begin
      if (s1_data_q[i*DW +: DW] == '0) zcnt_d = zcnt_d + ZW'(1);
    end
  end

  assign s2_en    = !s2_valid_q || out_ready;
  assign s1_en    = !s1_valid_q || s2_en;
  assign in_ready = s1_en;

  // NOTE: datapath registers are reset too, so the outputs read 0 during and after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_last_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_last_q  <= 1'b0;
      s2_zcnt_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so both stages shift on the same edge values.
      if (s1_en) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_data_q <= s1_data_d;
          s1_last_q <= in_last;
        end
      end
      if (s2_en) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_data_q <= s1_data_q;
          s2_last_q <= s1_last_q;
          s2_zcnt_q <= zcnt_d;
        end
      end
    end
  end

  assign out_valid    = s2_valid_q;
  assign out_data     = s2_data_q;
  assign out_last     = s2_last_q;
  assign out_zero_cnt = s2_zcnt_q;

endmodule

// File: tb/tb_relu_pipe.sv
// Directed and random-stall bench for relu_pipe with a per-lane reference scoreboard.
module tb_relu_pipe;

  localparam int DW = 16;
  localparam int CH = 6;
  localparam int ZW = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [DW*CH-1:0] in_data = '0;
  logic [1:0]       in_mode = 2'd0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [DW*CH-1:0] out_data;
  logic             out_last;
  logic [ZW-1:0]    out_zero_cnt;

  relu_pipe #(.DW(DW), .CH(CH), .LEAK_SH(3), .CLAMP(16'h0600), .ZW(ZW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mode(in_mode), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_zero_cnt(out_zero_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [DW*CH-1:0] data;
    logic             last;
    logic [ZW-1:0]    zc;
  } beat_t;

  beat_t exp_q[$];
  bit    sb_en = 1'b0;
  int    cyc = 0;
  int    acc_first = -1, out_first = -1, out_last_cyc = -1, out_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Integer-arithmetic reference: leaky uses floor division by 8, clamp at 0x600.
  function automatic logic [DW-1:0] ref_lane(input logic [DW-1:0] x, input logic [1:0] m);
    int v, r;
    v = int'($signed(x));
    case (m)
      2'd0:    r = v;
      2'd1:    r = (v < 0) ? 0 : v;
      2'd2:    r = (v >= 0) ? v : (v - 7) / 8;
      default: r = (v < 0) ? 0 : ((v > 1536) ? 1536 : v);
    endcase
    return r[DW-1:0];
  endfunction

  function automatic beat_t ref_beat(input logic [DW*CH-1:0] d, input logic [1:0] m, input logic l);
    beat_t b;
    b.data = '0;
    b.zc   = '0;
    b.last = l;
    for (int i = 0; i < CH; i++) begin
      b.data[i*DW +: DW] = ref_lane(d[i*DW +: DW], m);
      if (b.data[i*DW +: DW] == 16'h0000) b.zc = b.zc + 3'd1;
    end
    return b;
  endfunction

  function automatic logic [DW*CH-1:0] rand_data();
    logic [DW*CH-1:0] d;
    logic [DW-1:0]    v;
    d = '0;
    for (int i = 0; i < CH; i++) begin
      case ($urandom_range(0, 8))
        0: v = 16'h0000;
        1: v = 16'h0001;
        2: v = 16'hFFFF;
        3: v = 16'h7FFF;
        4: v = 16'h8000;
        5: v = 16'h0600;
        6: v = 16'h0601;
        default: v = 16'($urandom);
      endcase
      d[i*DW +: DW] = v;
    end
    return d;
  endfunction

  // Scoreboard: compares the head beat every valid cycle (also proves stability under stall).
  always @(negedge clk) begin
    if (!rst && sb_en) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_beat", out_valid, 1'b0);
        end else begin
          check("sb_data", out_data, exp_q[0].data);
          check("sb_last", out_last, exp_q[0].last);
          check("sb_zero_cnt", out_zero_cnt, exp_q[0].zc);
          if (out_ready) begin
            void'(exp_q.pop_front());
            if (out_first < 0) out_first = cyc;
            out_last_cyc = cyc;
            out_cnt++;
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_beat(in_data, in_mode, in_last));
        if (acc_first < 0) acc_first = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int bound);
    int k = 0;
    while (exp_q.size() != 0 && k < bound) begin
      tick();
      k++;
    end
    check("drain_timeout", 128'(exp_q.size()), 128'd0);
    tick();
    tick();
  endtask

  // Presents beats with out_ready held low; returns how many were accepted.
  task automatic fill_stalled(input int cycles, output int accepted);
    bit acc;
    accepted = 0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = rand_data();
    in_mode   = 2'($urandom_range(0, 3));
    in_last   = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      tick();
      if (acc) begin
        accepted++;
        in_data = rand_data();
        in_mode = 2'($urandom_range(0, 3));
      end
    end
  endtask

  logic [DW*CH-1:0] sweep_in;
  logic [DW*CH-1:0] sweep_exp [4];
  logic [ZW-1:0]    sweep_zc  [4];

  initial begin
    int accepted, sent, guard;
    bit acc;

    sweep_in     = 96'h7FFF_0700_0005_0000_FFFF_FFF0;
    sweep_exp[0] = 96'h7FFF_0700_0005_0000_FFFF_FFF0;  sweep_zc[0] = 3'd1;
    sweep_exp[1] = 96'h7FFF_0700_0005_0000_0000_0000;  sweep_zc[1] = 3'd3;
    sweep_exp[2] = 96'h7FFF_0700_0005_0000_FFFF_FFFE;  sweep_zc[2] = 3'd1;
    sweep_exp[3] = 96'h0600_0600_0005_0000_0000_0000;  sweep_zc[3] = 3'd3;

    // Reset and idle
    tick();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_out_zero_cnt", out_zero_cnt, '0);
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1'b1);
    check("post_rst_out_valid", out_valid, 1'b0);

    // Mode sweep with hand-computed results and exact latency
    out_ready = 1'b1;
    for (int m = 0; m < 4; m++) begin
      in_valid = 1'b1;
      in_data  = sweep_in;
      in_mode  = 2'(m);
      in_last  = (m == 3);
      #1;
      check("sweep_in_ready", in_ready, 1'b1);
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
      check("sweep_lat_edge1", out_valid, 1'b0);
      tick();
      check("sweep_lat_edge2", out_valid, 1'b1);
      check($sformatf("sweep_data_m%0d", m), out_data, sweep_exp[m]);
      check($sformatf("sweep_zc_m%0d", m), out_zero_cnt, sweep_zc[m]);
      check($sformatf("sweep_last_m%0d", m), out_last, (m == 3));
      tick();
      check("sweep_drained", out_valid, 1'b0);
    end

    // Latency and throughput: 10 back-to-back beats
    sb_en = 1'b1;
    acc_first = -1; out_first = -1; out_last_cyc = -1; out_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = rand_data();
      in_mode  = 2'(i % 4);
      in_last  = (i == 9);
      @(negedge clk);
      check("tp_in_ready", in_ready, 1'b1);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    wait_drain(20);
    check("tp_latency", 128'(out_first - acc_first), 128'd2);
    check("tp_out_count", 128'(out_cnt), 128'd10);
    check("tp_consecutive", 128'(out_last_cyc - out_first), 128'd9);

    // Backpressure: only two beats buffered, then drain in order
    fill_stalled(6, accepted);
    check("bp_accepted", 128'(accepted), 128'd2);
    check("bp_in_ready_low", in_ready, 1'b0);
    check("bp_out_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    #1;
    check("bp_accept_and_emit", in_ready, 1'b1);
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      tick();
      if (!acc) b--;
      in_data = rand_data();
      in_last = (b == 1);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    wait_drain(20);

    // Random stalls, 1000 beats
    sent = 0;
    guard = 0;
    in_valid = 1'b0;
    while (sent < 1000 && guard < 20000) begin
      if (!in_valid && $urandom_range(0, 9) < 7) begin
        in_valid = 1'b1;
        in_data  = rand_data();
        in_mode  = 2'($urandom_range(0, 3));
        in_last  = ($urandom_range(0, 15) == 0);
      end
      out_ready = ($urandom_range(0, 9) < 6);
      @(negedge clk);
      acc = in_valid && in_ready;
      tick();
      guard++;
      if (acc) begin
        sent++;
        in_valid = 1'b0;
      end
    end
    check("rand_sent", 128'(sent), 128'd1000);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_drain(50);

    // Mid-stream reset with the pipeline full
    fill_stalled(4, accepted);
    check("mrst_full", in_ready, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("mrst_out_valid", out_valid, 1'b0);
    check("mrst_out_data", out_data, '0);
    check("mrst_out_last", out_last, 1'b0);
    check("mrst_out_zero_cnt", out_zero_cnt, '0);
    exp_q.delete();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("mrst_in_ready", in_ready, 1'b1);
    for (int c = 0; c < 6; c++) tick();
    check("mrst_no_ghost", out_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
